// File: rtl/boot_loader.sv
// boot_loader: byte-stream boot loader. Receives a framed little-endian
// stream (LEN, N data words, CSUM), writes each assembled word to the
// memory's bootloader port at incrementing word addresses while holding
// the CPU off the memory, and verifies the trailing checksum.

module boot_loader #(
   parameter int ADDR_W    = 13,
   parameter int MAX_WORDS = 8192
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        debug,
   output logic        boot_we,
   output logic [31:0] data_cpu,
   output logic [31:0] waddr_cpu,
   output logic        done,
   output logic        err
);

   // Word counter must be able to hold MAX_WORDS itself.
   localparam int          CNT_W       = $clog2(MAX_WORDS + 1);
   localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_CSUM  = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_t;

   // Little-endian byte assembly: the newest byte enters at the top, so
   // after four shifts the first byte of the group sits in [7:0].
   function automatic logic [31:0] shift_in_byte(input logic [31:0] cur,
                                                 input logic [7:0]  b);
      return {b, cur[31:8]};
   endfunction

   state_t             state_q, state_d;
   logic [1:0]         byte_cnt_q, byte_cnt_d;
   logic [31:0]        len_q, len_d;
   logic [31:0]        shift_q, shift_d;
   logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [31:0]        acc_q, acc_d;

   logic               rx_ready_q, rx_ready_d;
   logic               debug_q, debug_d;
   logic               boot_we_q, boot_we_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [31:0]        data_q, data_d;
   logic [31:0]        waddr_q, waddr_d;

   logic               accept_s;
   logic               last_byte_s;
   logic [31:0]        len_word_s;
   logic [31:0]        byte_word_s;
   logic               last_word_s;
   logic               load_entry_s;

   // Handshake and assembled-value helpers shared by the FSM and datapath.
   always_comb begin
      accept_s     = rx_valid & rx_ready_q;
      last_byte_s  = (byte_cnt_q == 2'd3);
      len_word_s   = shift_in_byte(len_q, rx_byte);
      byte_word_s  = shift_in_byte(shift_q, rx_byte);
      last_word_s  = ((32'(word_cnt_q) + 32'd1) == len_q);
      load_entry_s = (state_d == ST_LEN) && (state_q != ST_LEN);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: frame sequencing, length and checksum decisions.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d = ST_LEN;
            end else begin
               state_d = state_q;
            end
         end
         ST_LEN: begin
            if (accept_s && last_byte_s) begin
               if (len_word_s > MAX_WORDS_W) begin
                  state_d = ST_ERR;
               end else if (len_word_s == 32'd0) begin
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_LEN;
            end
         end
         ST_DATA: begin
            if (accept_s && last_byte_s) begin
               state_d = ST_WRITE;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_WRITE: begin
            if (last_word_s) begin
               state_d = ST_CSUM;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_CSUM: begin
            if (accept_s && last_byte_s) begin
               if (byte_word_s == acc_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ERR;
               end
            end else begin
               state_d = ST_CSUM;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath next-state: byte/word counters, address and checksum.
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      len_d      = len_q;
      shift_d    = shift_q;
      word_cnt_d = word_cnt_q;
      addr_d     = addr_q;
      acc_d      = acc_q;
      if (load_entry_s) begin
         byte_cnt_d = 2'd0;
         len_d      = 32'd0;
         shift_d    = 32'd0;
         word_cnt_d = '0;
         addr_d     = '0;
         acc_d      = 32'd0;
      end else if (accept_s) begin
         byte_cnt_d = byte_cnt_q + 2'd1;
         if (state_q == ST_LEN) begin
            len_d = len_word_s;
         end else begin
            shift_d = byte_word_s;
         end
      end else if (state_q == ST_WRITE) begin
         // data_q holds the word being written this cycle.
         acc_d      = acc_q + data_q;
         addr_d     = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
         word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         byte_cnt_d = byte_cnt_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_cnt_q <= 2'd0;
         len_q      <= 32'd0;
         shift_q    <= 32'd0;
         word_cnt_q <= '0;
         addr_q     <= '0;
         acc_q      <= 32'd0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         len_q      <= len_d;
         shift_q    <= shift_d;
         word_cnt_q <= word_cnt_d;
         addr_q     <= addr_d;
         acc_q      <= acc_d;
      end
   end

   // Output decode from the next state so every output is a flop that is
   // aligned with the state it describes.
   always_comb begin
      rx_ready_d = 1'b0;
      debug_d    = 1'b1;
      boot_we_d  = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      data_d     = data_q;
      waddr_d    = waddr_q;
      case (state_d)
         ST_IDLE: begin
            debug_d = 1'b0;
         end
         ST_LEN, ST_DATA, ST_CSUM: begin
            rx_ready_d = 1'b1;
         end
         ST_WRITE: begin
            // WRITE is only entered on the 4th data byte, so the word is
            // the shift register plus the byte accepted this cycle.
            boot_we_d = 1'b1;
            data_d    = byte_word_s;
            waddr_d   = {{(32-ADDR_W){1'b0}}, addr_q};
         end
         ST_DONE: begin
            debug_d = 1'b0;
            done_d  = 1'b1;
         end
         ST_ERR: begin
            // The CPU stays held off a memory with a failed image.
            err_d = 1'b1;
         end
         default: begin
            debug_d = 1'b0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_ready_q <= 1'b0;
         debug_q    <= 1'b0;
         boot_we_q  <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         data_q     <= 32'd0;
         waddr_q    <= 32'd0;
      end else begin
         rx_ready_q <= rx_ready_d;
         debug_q    <= debug_d;
         boot_we_q  <= boot_we_d;
         done_q     <= done_d;
         err_q      <= err_d;
         data_q     <= data_d;
         waddr_q    <= waddr_d;
      end
   end

   assign rx_ready  = rx_ready_q;
   assign debug     = debug_q;
   assign boot_we   = boot_we_q;
   assign data_cpu  = data_q;
   assign waddr_cpu = waddr_q;
   assign done      = done_q;
   assign err       = err_q;

   boot_loader_chk #(
      .ADDR_W (ADDR_W)
   ) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_ready  (rx_ready_q),
      .debug     (debug_q),
      .boot_we   (boot_we_q),
      .waddr_cpu (waddr_q),
      .done      (done_q),
      .err       (err_q)
   );

endmodule

// boot_loader_chk: protocol invariants of the loader outputs.
module boot_loader_chk #(
   parameter int ADDR_W = 13
) (
   input logic        clk,
   input logic        rst_n,
   input logic        rx_ready,
   input logic        debug,
   input logic        boot_we,
   input logic [31:0] waddr_cpu,
   input logic        done,
   input logic        err
);

   // A write cycle never accepts a byte.
   a_we_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
      boot_we |-> !rx_ready);

   // Write strobe lasts exactly one cycle.
   a_we_single: assert property (@(posedge clk) disable iff (!rst_n)
      boot_we |=> !boot_we);

   // Writes happen only while the CPU is held.
   a_we_debug: assert property (@(posedge clk) disable iff (!rst_n)
      boot_we |-> debug);

   // Pass and fail are mutually exclusive.
   a_done_err: assert property (@(posedge clk) disable iff (!rst_n)
      !(done && err));

   // Address bits above the bank width stay zero.
   a_addr_hi: assert property (@(posedge clk) disable iff (!rst_n)
      (waddr_cpu >> ADDR_W) == 32'd0);

endmodule
